// File: rtl/sin_cos_osc.sv
// sin_cos_osc: restartable quadrature oscillator using the
// modified coupled-form (Minsky) recurrence, one sample per clock.
module sin_cos_osc #(
    parameter int WIDTH = 16,
    parameter int N_MAX = 8,
    parameter int CNT_W = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           stop,
    input  logic [$clog2(N_MAX+1)-1:0]     shift,
    input  logic [WIDTH-1:0]               amp,
    output logic                           busy,
    output logic                           valid,
    output logic signed [WIDTH-1:0]        sin,
    output logic signed [WIDTH-1:0]        cos,
    output logic                           period_done,
    output logic [CNT_W-1:0]               period_count
);

    function automatic int p_of(input int s);
        return ((1 << s) * 628) / 100 + 1;
    endfunction

    localparam int SW    = $clog2(N_MAX + 1);
    localparam int P_MAX = p_of(N_MAX);
    localparam int IDX_W = $clog2(P_MAX);
    localparam logic [WIDTH-1:0] ACAP = WIDTH'(1) << (WIDTH - 2);
    localparam logic [SW-1:0]    SMAX = SW'(N_MAX);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [SW-1:0]            r_s;
    logic [WIDTH-1:0]         r_a;
    logic [IDX_W-1:0]         r_idx;
    logic signed [WIDTH-1:0]  r_sin;
    logic signed [WIDTH-1:0]  r_cos;
    logic                     r_pend;
    logic                     r_done;
    logic [CNT_W-1:0]         r_cnt;

    logic [IDX_W-1:0]         w_plast_tab [N_MAX+1];
    logic [IDX_W-1:0]         w_plast;
    logic [IDX_W-1:0]         w_idx_inc;
    logic                     w_last;
    logic [SW-1:0]            w_s_clamp;
    logic [WIDTH-1:0]         w_a_clamp;
    logic signed [WIDTH-1:0]  w_cos_n;
    logic signed [WIDTH-1:0]  w_sin_n;

    // Last sample index per step shift, built at elaboration.
    for (genvar g = 0; g <= N_MAX; g++) begin : g_ptab
        assign w_plast_tab[g] = IDX_W'(p_of(g) - 1);
    end

    assign w_plast   = w_plast_tab[r_s];
    assign w_idx_inc = r_idx + 1'b1;
    assign w_last    = (r_state == S_RUN) && (r_idx == w_plast);
    assign w_s_clamp = (shift > SMAX) ? SMAX : shift;
    assign w_a_clamp = (amp > ACAP) ? ACAP : amp;

    // The sine update uses the freshly updated cosine (Minsky form).
    assign w_cos_n = r_cos - (r_sin >>> r_s);
    assign w_sin_n = r_sin + (w_cos_n >>> r_s);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state: leave RUN only at a period boundary.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last && (r_pend || stop)) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: load on start, step recurrence, reload per period.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s    <= '0;
            r_a    <= '0;
            r_idx  <= '0;
            r_sin  <= '0;
            r_cos  <= '0;
            r_pend <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_s    <= w_s_clamp;
                r_a    <= w_a_clamp;
                r_idx  <= '0;
                r_sin  <= '0;
                r_cos  <= $signed(w_a_clamp);
                r_pend <= stop;
                r_done <= 1'b0;
                r_cnt  <= '0;
            end
        end else begin
            if (stop) r_pend <= 1'b1;
            if (w_last) begin
                r_cnt  <= r_cnt + 1'b1;
                r_idx  <= '0;
                r_done <= 1'b0;
                r_sin  <= '0;
                if (r_pend || stop) begin
                    r_cos  <= '0;
                    r_pend <= 1'b0;
                end else begin
                    r_cos  <= $signed(r_a);
                end
            end else begin
                r_sin  <= w_sin_n;
                r_cos  <= w_cos_n;
                r_idx  <= w_idx_inc;
                r_done <= (w_idx_inc == w_plast);
            end
        end
    end

    assign busy         = (r_state == S_RUN);
    assign valid        = busy;
    assign sin          = r_sin;
    assign cos          = r_cos;
    assign period_done  = r_done;
    assign period_count = r_cnt;

endmodule

// File: tb/tb_sin_cos_osc.sv
// tb_sin_cos_osc: checks sin_cos_osc every cycle against an
// integer reference model, plus hand-computed sample values.
module tb_sin_cos_osc;

    localparam int WIDTH = 16;
    localparam int N_MAX = 8;
    localparam int CNT_W = 3;
    localparam int SW    = $clog2(N_MAX + 1);

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic                    stop = 1'b0;
    logic [SW-1:0]           shift = '0;
    logic [WIDTH-1:0]        amp = '0;
    logic                    busy;
    logic                    valid;
    logic signed [WIDTH-1:0] d_sin;
    logic signed [WIDTH-1:0] d_cos;
    logic                    done;
    logic [CNT_W-1:0]        cnt;

    int n_chk = 0;
    int n_err = 0;

    int m_run = 0;
    int m_s = 0;
    int m_a = 0;
    int m_sin = 0;
    int m_cos = 0;
    int m_idx = 0;
    int m_cnt = 0;
    int m_pend = 0;

    sin_cos_osc #(
        .WIDTH(WIDTH), .N_MAX(N_MAX), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(rst), .start(start), .stop(stop),
        .shift(shift), .amp(amp), .busy(busy), .valid(valid),
        .sin(d_sin), .cos(d_cos), .period_done(done),
        .period_count(cnt)
    );

    always #5 clk = ~clk;

    function automatic int npts(input int s);
        return ((2 ** s) * 628) / 100 + 1;
    endfunction

    function automatic int wrapw(input int x);
        int y;
        y = x & ((1 << WIDTH) - 1);
        if (y >= (1 << (WIDTH - 1))) y = y - (1 << WIDTH);
        return y;
    endfunction

    task automatic chk(input string nm, input int act,
                       input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int c2;
        bit last;
        if (rst) begin
            m_run = 0; m_sin = 0; m_cos = 0; m_idx = 0;
            m_cnt = 0; m_pend = 0; m_s = 0; m_a = 0;
        end else if (m_run == 0) begin
            if (start) begin
                m_run  = 1;
                m_s    = (int'(shift) > N_MAX) ? N_MAX : int'(shift);
                m_a    = (int'(amp) > 16384) ? 16384 : int'(amp);
                m_sin  = 0;
                m_cos  = m_a;
                m_idx  = 0;
                m_cnt  = 0;
                m_pend = int'(stop);
            end
        end else begin
            last = (m_idx == npts(m_s) - 1);
            if (last) begin
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                m_sin = 0;
                m_idx = 0;
                if (m_pend != 0 || stop) begin
                    m_run = 0; m_cos = 0; m_pend = 0;
                end else begin
                    m_cos = m_a;
                end
            end else begin
                if (stop) m_pend = 1;
                c2    = wrapw(m_cos - (m_sin >>> m_s));
                m_sin = wrapw(m_sin + (c2 >>> m_s));
                m_cos = c2;
                m_idx = m_idx + 1;
            end
        end
    endtask

    task automatic tick();
        int ed;
        @(posedge clk);
        model_step();
        #1;
        ed = (m_run != 0 && m_idx == npts(m_s) - 1) ? 1 : 0;
        chk("busy", int'(busy), m_run);
        chk("valid", int'(valid), m_run);
        chk("sin", int'(d_sin), m_sin);
        chk("cos", int'(d_cos), m_cos);
        chk("period_done", int'(done), ed);
        chk("period_count", int'(cnt), m_cnt);
    endtask

    task automatic go(input int sh, input int am, input bit st);
        shift = SW'(sh);
        amp   = WIDTH'(am);
        start = 1'b1;
        stop  = st;
        tick();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (busy && n < maxc) begin
            tick();
            n++;
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic pin(input string nm, input int s, input int c);
        chk({nm, "_sin"}, int'(d_sin), s);
        chk({nm, "_cos"}, int'(d_cos), c);
    endtask

    initial begin
        // reset held 3 cycles while start toggles
        for (int i = 0; i < 3; i++) begin
            rst = 1'b1;
            start = (i % 2 == 0);
            tick();
            chk("rst_busy", int'(busy), 0);
            chk("rst_sin", int'(d_sin), 0);
        end
        rst = 1'b0;
        start = 1'b0;
        tick();
        chk("idle_cnt", int'(cnt), 0);

        // basic tone s=5 amp=8192
        go(5, 8192, 1'b0);
        pin("t5_0", 0, 8192);
        tick();
        pin("t5_1", 256, 8192);
        tick();
        pin("t5_2", 511, 8184);
        repeat (198) tick();
        chk("t5_done200", int'(done), 1);
        tick();
        pin("t5_reload", 0, 8192);
        chk("t5_cnt1", int'(cnt), 1);

        // graceful stop mid period 1, start during RUN ignored
        repeat (50) tick();
        stop = 1'b1;
        start = 1'b1;
        tick();
        stop = 1'b0;
        start = 1'b0;
        wait_idle(400);
        chk("stop_cnt2", int'(cnt), 2);
        repeat (3) tick();

        // s=0 sequence and counter wrap
        go(0, 8192, 1'b0);
        pin("s0_0", 0, 8192);
        tick();
        pin("s0_1", 8192, 8192);
        tick();
        pin("s0_2", 8192, 0);
        tick();
        pin("s0_3", 0, -8192);
        tick();
        pin("s0_4", -8192, -8192);
        repeat (45) tick();
        chk("cnt_7", int'(cnt), 7);
        repeat (7) tick();
        chk("cnt_wrap", int'(cnt), 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(20);

        // amplitude and shift clamp
        go(15, 16'hFFFF, 1'b0);
        pin("clamp_0", 0, 16384);
        repeat (1606) tick();
        chk("clamp_not_done", int'(done), 0);
        tick();
        chk("clamp_done1607", int'(done), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("clamp_exit", int'(busy), 0);
        chk("clamp_cnt", int'(cnt), 1);

        // start and stop together: exactly one period
        go(0, 1000, 1'b1);
        repeat (6) tick();
        chk("ss_done", int'(done), 1);
        tick();
        chk("ss_busy", int'(busy), 0);
        chk("ss_cnt", int'(cnt), 1);
        repeat (3) tick();
        chk("ss_hold_cnt", int'(cnt), 1);

        // reset mid run at sample 100
        go(5, 5000, 1'b0);
        repeat (100) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pin("rst_mid", 0, 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_cnt", int'(cnt), 0);
        tick();

        // randomized runs
        for (int r = 0; r < 12; r++) begin
            go(int'($urandom_range(0, 15)),
               int'($urandom_range(0, 65535)), 1'b0);
            for (int k = 0; k < int'($urandom_range(50, 700)); k++) begin
                stop  = ($urandom_range(0, 99) == 0);
                start = ($urandom_range(0, 19) == 0);
                rst   = ($urandom_range(0, 599) == 0);
                shift = SW'($urandom_range(0, 15));
                amp   = WIDTH'($urandom_range(0, 65535));
                tick();
            end
            rst = 1'b0;
            start = 1'b0;
            stop = 1'b1;
            tick();
            stop = 1'b0;
            wait_idle(2000);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
